// File: rtl/bf_round_pipe.sv
// Two-stage float narrowing unit: FP32-like accumulator word to bfloat-like
// output with RNE/RTZ rounding, subnormal flush, overflow to inf, quiet NaN.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/rnd_mode;
// out_valid/out_ready/out_data/out_flags {overflow, flushed, inexact};
// flush_cnt/inexact_cnt when ROUND_STATS_EN is defined.
module bf_round_pipe #(
  parameter int EXP_W    = 8,
  parameter int IN_MAN_W = 23,
  parameter int MAN_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+IN_MAN_W:0]   in_data,
  input  logic                      rnd_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MAN_W:0]      out_data,
`ifdef ROUND_STATS_EN
  output logic [15:0]               flush_cnt,
  output logic [15:0]               inexact_cnt,
`endif
  output logic [2:0]                out_flags
);

  localparam int D = IN_MAN_W - MAN_W;
  localparam logic [MAN_W-1:0] QBIT = MAN_W'(1) << (MAN_W - 1);

  typedef enum logic [1:0] {
    C_ZERO, C_INF, C_NAN, C_NORM
  } cls_e;

  // input field split
  logic                in_sign;
  logic [EXP_W-1:0]    in_exp;
  logic [IN_MAN_W-1:0] in_man;
  logic [MAN_W-1:0]    in_keep;
  logic                guard;
  logic                sticky;

  assign in_sign = in_data[EXP_W+IN_MAN_W];
  assign in_exp  = in_data[EXP_W+IN_MAN_W-1:IN_MAN_W];
  assign in_man  = in_data[IN_MAN_W-1:0];
  assign in_keep = in_man[IN_MAN_W-1:D];
  assign guard   = in_man[D-1];

  generate
    if (D > 1) begin : g_sticky
      assign sticky = |in_man[D-2:0];
    end else begin : g_nosticky
      assign sticky = 1'b0;
    end
  endgenerate

  // stage registers
  logic             s1_valid_q, s1_valid_d;
  cls_e             cls_q, cls_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] keep_q, keep_d;
  logic             inc_q, inc_d;
  logic             inx_q, inx_d;
  logic             nz_q, nz_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [EXP_W+MAN_W:0] data_q, data_d;
  logic [2:0]           flags_q, flags_d;

  logic s2_en;
  logic s1_load;
  logic s1_adv;
  logic out_hs;

  assign s2_en    = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_en;
  assign s1_load  = in_valid & in_ready;
  assign s1_adv   = s1_valid_q & s2_en;
  assign out_hs   = s2_valid_q & out_ready;

  // stage 1: classify and decide the rounding increment
  always_comb begin
    s1_valid_d = s1_valid_q;
    cls_d      = cls_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    keep_d     = keep_q;
    inc_d      = inc_q;
    inx_d      = inx_q;
    nz_d       = nz_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      sign_d     = in_sign;
      exp_d      = in_exp;
      keep_d     = in_keep;
      nz_d       = |in_man;
      inx_d      = guard | sticky;
      inc_d      = !rnd_mode & guard & (sticky | in_keep[0]);
      if (in_exp == '0)
        cls_d = C_ZERO;
      else if (in_exp == '1)
        cls_d = (in_man == '0) ? C_INF : C_NAN;
      else
        cls_d = C_NORM;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // stage 2: apply increment, build result and flags
  logic [EXP_W+MAN_W-1:0] sum;

  assign sum = {exp_q, keep_q} + {{(EXP_W+MAN_W-1){1'b0}}, inc_q};

  always_comb begin
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    flags_d    = flags_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        unique case (cls_q)
          C_ZERO: begin
            data_d  = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d = {1'b0, nz_q, 1'b0};
          end
          C_INF: begin
            data_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 3'b000;
          end
          C_NAN: begin
            data_d  = {sign_q, {EXP_W{1'b1}}, keep_q | QBIT};
            flags_d = 3'b000;
          end
          default: begin
            // a carry into an all-ones exponent already leaves mantissa 0
            data_d  = {sign_q, sum};
            flags_d = {sum[EXP_W+MAN_W-1:MAN_W] == '1, 1'b0, inx_q};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      cls_q      <= C_ZERO;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      keep_q     <= '0;
      inc_q      <= 1'b0;
      inx_q      <= 1'b0;
      nz_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      cls_q      <= cls_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      keep_q     <= keep_d;
      inc_q      <= inc_d;
      inx_q      <= inx_d;
      nz_q       <= nz_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = data_q;
  assign out_flags = flags_q;

`ifdef ROUND_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] inexact_cnt_q, inexact_cnt_d;

  // counted at the output handshake so stalled words are not yet included
  always_comb begin
    flush_cnt_d   = flush_cnt_q;
    inexact_cnt_d = inexact_cnt_q;
    if (out_hs && flags_q[1] && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
    if (out_hs && flags_q[0] && inexact_cnt_q != 16'hFFFF)
      inexact_cnt_d = inexact_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q   <= '0;
      inexact_cnt_q <= '0;
    end else begin
      flush_cnt_q   <= flush_cnt_d;
      inexact_cnt_q <= inexact_cnt_d;
    end
  end

  assign flush_cnt   = flush_cnt_q;
  assign inexact_cnt = inexact_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_bf_round_pipe.sv
// Directed bench for bf_round_pipe: rounding, flush, specials,
// backpressure, mid-flight reset and (with ROUND_STATS_EN) counters.
module tb_bf_round_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;
`ifdef ROUND_STATS_EN
  logic [15:0] flush_cnt;
  logic [15:0] inexact_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_round_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .rnd_mode(rnd_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef ROUND_STATS_EN
    .flush_cnt(flush_cnt),
    .inexact_cnt(inexact_cnt),
`endif
    .out_flags(out_flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d,
                         input logic [2:0] f);
    chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_d"}, {16'd0, out_data}, {16'd0, d});
    chk({tag, "_f"}, {29'd0, out_flags}, {29'd0, f});
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {31'd0, out_valid}, 32'd0);
  endtask

  // single isolated word: accept, then result two edges later
  task automatic one(input string tag, input logic [31:0] d,
                     input logic m, input logic [15:0] ed,
                     input logic [2:0] ef);
    in_valid = 1'b1;
    in_data  = d;
    rnd_mode = m;
    step();
    in_valid = 1'b0;
    rnd_mode = ~m;
    chk_idle({tag, "_lat1"});
    step();
    chk_out(tag, ed, ef);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_idle("rst_v");
    chk("rst_d", {16'd0, out_data}, 32'd0);
    chk("rst_f", {29'd0, out_flags}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    // RNE back-to-back
    in_valid = 1'b1;
    in_data  = 32'h3F800001;
    step();
    chk_idle("b2b_lat");
    in_data = 32'h3F808000;
    step();
    chk_out("rne_sticky", 16'h3F80, 3'b001);
    in_data = 32'h3F818000;
    step();
    chk_out("rne_tie_even", 16'h3F80, 3'b001);
    in_data = 32'h3FFF8000;
    step();
    chk_out("rne_tie_odd", 16'h3F82, 3'b001);
    in_valid = 1'b0;
    step();
    chk_out("rne_carry", 16'h4000, 3'b001);
    step();
    chk_idle("b2b_drain");

    // flush to signed zero
    one("fl_sub", 32'h00001234, 1'b0, 16'h0000, 3'b010);
    one("fl_neg", 32'h80400000, 1'b0, 16'h8000, 3'b010);
    one("fl_nzero", 32'h80000000, 1'b0, 16'h8000, 3'b000);

    // specials
    one("ovf_rne", 32'h7F7FFFFF, 1'b0, 16'h7F80, 3'b101);
    one("max_rtz", 32'h7F7FFFFF, 1'b1, 16'h7F7F, 3'b001);
    one("qnan", 32'h7F800001, 1'b0, 16'h7FC0, 3'b000);
    one("ninf", 32'hFF800000, 1'b0, 16'hFF80, 3'b000);
    one("rtz_odd", 32'h3F818000, 1'b1, 16'h3F81, 3'b001);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3F800000;
    chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    in_data = 32'h40000000;
    step();
    chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
    in_data = 32'h40400000;
    step();
    chk("bp_rdy3", {31'd0, in_ready}, 32'd0);
    chk_out("bp_hold1", 16'h3F80, 3'b000);
    step();
    chk_out("bp_hold2", 16'h3F80, 3'b000);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp_o2", 16'h4000, 3'b000);
    step();
    chk_out("bp_o3", 16'h4040, 3'b000);
    step();
    chk_idle("bp_drain");

    // reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00001234;
    step();
    in_data = 32'h3F800001;
    step();
    in_valid = 1'b0;
    step();
    chk_out("pre_rst", 16'h0000, 3'b010);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst_v");
    chk("mid_rst_d", {16'd0, out_data}, 32'd0);
`ifdef ROUND_STATS_EN
    chk("mid_rst_fc", {16'd0, flush_cnt}, 32'd0);
    chk("mid_rst_ic", {16'd0, inexact_cnt}, 32'd0);
`endif
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    chk_idle("post_rst1");
    step();
    chk_idle("post_rst2");
    step();
    chk_idle("post_rst3");

    // stats: 3 flushed, 2 inexact, first two stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00001234;
    step();
    in_data = 32'h80400000;
    step();
    in_valid = 1'b0;
    step();
`ifdef ROUND_STATS_EN
    chk("st_stall_fc", {16'd0, flush_cnt}, 32'd0);
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00000001;
    step();
    in_data = 32'h3F800001;
    step();
    in_data = 32'h3F808000;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk_idle("st_drain");
`ifdef ROUND_STATS_EN
    chk("st_fc", {16'd0, flush_cnt}, 32'd3);
    chk("st_ic", {16'd0, inexact_cnt}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
